executs_mc: RTL and testbench

EXECUTS_MC -- requirements
Module: executs_mc

---
 rtl/executs_mc.sv | 216 +++++++++++++++++++++
 tb/tb_executs_mc.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/executs_mc.sv
`default_nettype none
// ============================================================================
// Module   : executs_mc
// Purpose  : MIPS-style execute stage; single-cycle ALU plus a shift-add
//            multiplier and a restoring divider sharing one accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module executs_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    input  logic [WIDTH-1:0] Sign_extend,
    input  logic [WIDTH-1:0] PC_plus_4,
    input  logic [5:0]       Function_opcode,
    input  logic [5:0]       Exe_opcode,
    input  logic [1:0]       ALUOp,
    input  logic [4:0]       Shamt,
    input  logic             Sftmd,
    input  logic             ALUSrc,
    input  logic             I_format,
    input  logic             Jrn,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [WIDTH-1:0] Add_Result,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [5:0] F_SLL   = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10, F_MFLO = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26, F_NOR  = 6'h27, F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [5:0] O_ADDI  = 6'h08, O_ADDIU = 6'h09, O_SLTI = 6'h0A;
    localparam logic [5:0] O_SLTIU = 6'h0B, O_ANDI  = 6'h0C, O_ORI  = 6'h0D;
    localparam logic [5:0] O_XORI  = 6'h0E, O_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] opb;

    logic [WIDTH-1:0] alu_val;
    logic             is_mul;
    logic             is_div;
    logic [WIDTH-1:0] add_val;
    logic [WIDTH-1:0] zimm;
    logic [WIDTH-1:0] lui_val;
    logic [SH_W-1:0]  sh_var;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;

    assign add_val = PC_plus_4 + (Sign_extend << 2);
    assign zimm    = {{(WIDTH-16){1'b0}}, Sign_extend[15:0]};
    assign lui_val = {{(WIDTH-16){Sign_extend[15]}}, Sign_extend[15:0]} << 16;
    assign sh_var  = Read_data_1[SH_W-1:0];

    always_comb begin
        alu_val = '0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        if (Jrn) begin
            alu_val = Read_data_1;
        end else if (I_format) begin
            case (Exe_opcode)
                O_ADDI, O_ADDIU: alu_val = Read_data_1 + Sign_extend;
                O_SLTI:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(Read_data_1) < $signed(Sign_extend))};
                O_SLTIU: alu_val = {{(WIDTH-1){1'b0}}, (Read_data_1 < Sign_extend)};
                O_ANDI:  alu_val = Read_data_1 & zimm;
                O_ORI:   alu_val = Read_data_1 | zimm;
                O_XORI:  alu_val = Read_data_1 ^ zimm;
                O_LUI:   alu_val = lui_val;
                default: alu_val = '0;
            endcase
        end else begin
            case (ALUOp)
                2'b10: begin
                    case (Function_opcode)
                        F_ADD, F_ADDU: alu_val = Read_data_1 + Read_data_2;
                        F_SUB, F_SUBU: alu_val = Read_data_1 - Read_data_2;
                        F_AND:  alu_val = Read_data_1 & Read_data_2;
                        F_OR:   alu_val = Read_data_1 | Read_data_2;
                        F_XOR:  alu_val = Read_data_1 ^ Read_data_2;
                        F_NOR:  alu_val = ~(Read_data_1 | Read_data_2);
                        F_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(Read_data_1) < $signed(Read_data_2))};
                        F_SLTU: alu_val = {{(WIDTH-1){1'b0}}, (Read_data_1 < Read_data_2)};
                        // shift functs only count as shifts when the decoder flags Sftmd
                        F_SLL:  if (Sftmd) alu_val = Read_data_2 << Shamt;
                        F_SRL:  if (Sftmd) alu_val = Read_data_2 >> Shamt;
                        F_SRA:  if (Sftmd) alu_val = $signed(Read_data_2) >>> Shamt;
                        F_SLLV: if (Sftmd) alu_val = Read_data_2 << sh_var;
                        F_SRLV: if (Sftmd) alu_val = Read_data_2 >> sh_var;
                        F_SRAV: if (Sftmd) alu_val = $signed(Read_data_2) >>> sh_var;
                        F_MFHI: alu_val = Hi;
                        F_MFLO: alu_val = Lo;
                        F_MULTU: is_mul = 1'b1;
                        F_DIVU:  is_div = 1'b1;
                        default: alu_val = '0;
                    endcase
                end
                2'b01:   alu_val = Read_data_1 - Read_data_2;
                2'b00:   alu_val = Read_data_1 + (ALUSrc ? Sign_extend : Read_data_2);
                default: alu_val = '0;
            endcase
        end
    end

    // Multiply: acc holds the running high half, low shifts the multiplier out.
    assign mul_sum  = {1'b0, acc} + (low[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, low[WIDTH-1:1]};

    // Divide: acc is the partial remainder, low shifts dividend out / quotient in.
    // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
    assign rem_sh  = {acc, low[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, opb});
    assign div_rem = div_ge ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];
    assign div_quo = {low[WIDTH-2:0], div_ge};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            low        <= '0;
            opb        <= '0;
            ALU_Result <= '0;
            Add_Result <= '0;
            Hi         <= '0;
            Lo         <= '0;
            Zero       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        Add_Result <= add_val;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        if (is_mul) begin
                            acc   <= '0;
                            low   <= Read_data_2;
                            opb   <= Read_data_1;
                            state <= MUL;
                        end else if (is_div) begin
                            acc   <= '0;
                            low   <= Read_data_1;
                            opb   <= Read_data_2;
                            state <= DIV;
                        end else begin
                            ALU_Result <= alu_val;
                            Zero       <= (alu_val == '0);
                            done       <= 1'b1;
                            state      <= FIN;
                        end
                    end
                end
                MUL: begin
                    {acc, low} <= mul_next;
                    cnt        <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        {Hi, Lo} <= mul_next;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                DIV: begin
                    acc <= div_rem;
                    low <= div_quo;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        Hi    <= div_rem;
                        Lo    <= div_quo;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_executs_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_executs_mc
// Purpose  : Scoreboard bench for executs_mc with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_executs_mc;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  Read_data_1 = '0, Read_data_2 = '0, Sign_extend = '0, PC_plus_4 = '0;
    logic [5:0]    Function_opcode = '0, Exe_opcode = '0;
    logic [1:0]    ALUOp = '0;
    logic [4:0]    Shamt = '0;
    logic          Sftmd = 1'b0, ALUSrc = 1'b0, I_format = 1'b0, Jrn = 1'b0;
    logic [W-1:0]  ALU_Result, Add_Result, Hi, Lo;
    logic          Zero, busy, done;

    executs_mc #(.WIDTH(W), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start),
        .Read_data_1(Read_data_1), .Read_data_2(Read_data_2),
        .Sign_extend(Sign_extend), .PC_plus_4(PC_plus_4),
        .Function_opcode(Function_opcode), .Exe_opcode(Exe_opcode),
        .ALUOp(ALUOp), .Shamt(Shamt), .Sftmd(Sftmd), .ALUSrc(ALUSrc),
        .I_format(I_format), .Jrn(Jrn),
        .ALU_Result(ALU_Result), .Add_Result(Add_Result), .Hi(Hi), .Lo(Lo),
        .Zero(Zero), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] rs, rt, imm, pc;
        logic [5:0]   funct, opc;
        logic [1:0]   aluop;
        logic [4:0]   shamt;
        logic         sftmd, alusrc, ifmt, jrn;
    } stim_t;

    typedef struct {
        logic [W-1:0] alu, add, hi, lo;
        logic         zero;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    logic [W-1:0] m_alu = '0, m_hi = '0, m_lo = '0;
    logic         m_zero = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: architectural meaning of each instruction, plain arithmetic.
    task automatic predict(input stim_t s, output exp_t e, output int lat);
        logic [2*W-1:0] p;
        logic [W-1:0]   zimm;
        bit             md;
        md    = 1'b0;
        lat   = 0;
        e.cyc = 0;
        e.add = s.pc + (s.imm << 2);
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.alu = '0;
        zimm  = {16'h0, s.imm[15:0]};
        if (s.jrn) begin
            e.alu = s.rs;
        end else if (s.ifmt) begin
            case (s.opc)
                6'h08, 6'h09: e.alu = s.rs + s.imm;
                6'h0A: e.alu = {31'b0, ($signed(s.rs) < $signed(s.imm))};
                6'h0B: e.alu = {31'b0, (s.rs < s.imm)};
                6'h0C: e.alu = s.rs & zimm;
                6'h0D: e.alu = s.rs | zimm;
                6'h0E: e.alu = s.rs ^ zimm;
                6'h0F: e.alu = {s.imm[15:0], 16'h0};
                default: e.alu = '0;
            endcase
        end else if (s.aluop == 2'b10) begin
            case (s.funct)
                6'h20, 6'h21: e.alu = s.rs + s.rt;
                6'h22, 6'h23: e.alu = s.rs - s.rt;
                6'h24: e.alu = s.rs & s.rt;
                6'h25: e.alu = s.rs | s.rt;
                6'h26: e.alu = s.rs ^ s.rt;
                6'h27: e.alu = ~(s.rs | s.rt);
                6'h2A: e.alu = {31'b0, ($signed(s.rs) < $signed(s.rt))};
                6'h2B: e.alu = {31'b0, (s.rs < s.rt)};
                6'h00: if (s.sftmd) e.alu = s.rt << s.shamt;
                6'h02: if (s.sftmd) e.alu = s.rt >> s.shamt;
                6'h03: if (s.sftmd) e.alu = $signed(s.rt) >>> s.shamt;
                6'h04: if (s.sftmd) e.alu = s.rt << s.rs[4:0];
                6'h06: if (s.sftmd) e.alu = s.rt >> s.rs[4:0];
                6'h07: if (s.sftmd) e.alu = $signed(s.rt) >>> s.rs[4:0];
                6'h10: e.alu = m_hi;
                6'h12: e.alu = m_lo;
                6'h19: begin
                    md = 1'b1;
                    p  = {32'h0, s.rs} * {32'h0, s.rt};
                    e.hi = p[2*W-1:W];
                    e.lo = p[W-1:0];
                end
                6'h1B: begin
                    md = 1'b1;
                    if (s.rt == 0) begin
                        e.lo = '1;
                        e.hi = s.rs;
                    end else begin
                        e.lo = s.rs / s.rt;
                        e.hi = s.rs % s.rt;
                    end
                end
                default: e.alu = '0;
            endcase
        end else if (s.aluop == 2'b01) begin
            e.alu = s.rs - s.rt;
        end else if (s.aluop == 2'b00) begin
            e.alu = s.rs + (s.alusrc ? s.imm : s.rt);
        end
        if (md) begin
            e.alu  = m_alu;
            e.zero = m_zero;
            lat    = W;
        end else begin
            e.zero = (e.alu == 0);
        end
        m_alu  = e.alu;
        m_zero = e.zero;
        m_hi   = e.hi;
        m_lo   = e.lo;
    endtask

    task automatic drive(input stim_t s);
        Read_data_1 = s.rs; Read_data_2 = s.rt; Sign_extend = s.imm; PC_plus_4 = s.pc;
        Function_opcode = s.funct; Exe_opcode = s.opc; ALUOp = s.aluop; Shamt = s.shamt;
        Sftmd = s.sftmd; ALUSrc = s.alusrc; I_format = s.ifmt; Jrn = s.jrn;
    endtask

    function automatic stim_t gen_rand();
        stim_t      s;
        int         k;
        logic [5:0] rtbl [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                  6'h10, 6'h12};
        s.rs = $urandom; s.rt = $urandom; s.imm = $urandom; s.pc = $urandom;
        if ($urandom_range(0, 3) == 0) s.rt = s.rs;
        if ($urandom_range(0, 3) == 0) s.rt = $urandom_range(0, 40);
        s.shamt = 5'($urandom); s.sftmd = 1'($urandom); s.alusrc = 1'($urandom);
        s.ifmt = 1'b0; s.jrn = 1'b0; s.aluop = 2'b10;
        s.funct = 6'($urandom); s.opc = 6'($urandom);
        k = $urandom_range(0, 27);
        if (k < 18) begin
            s.funct = rtbl[k];
            if (k >= 10 && k <= 15) s.sftmd = ($urandom_range(0, 7) != 0);
        end else if (k == 18) begin
            s.funct = 6'h19;
        end else if (k == 19) begin
            s.funct = 6'h1B;
            if ($urandom_range(0, 3) == 0) s.rt = '0;
        end else if (k <= 21) begin
            s.ifmt = 1'b1;
            s.opc  = 6'h08 + 6'($urandom_range(0, 7));
            s.imm  = {{16{s.imm[15]}}, s.imm[15:0]};
        end else if (k == 22) begin
            s.aluop = 2'b01;
        end else if (k == 23) begin
            s.aluop = 2'b00;
        end else if (k == 24) begin
            s.jrn = 1'b1; s.aluop = 2'($urandom); s.ifmt = 1'($urandom);
        end else if (k == 25) begin
            s.funct = 6'h3F;
        end else if (k == 26) begin
            s.aluop = 2'b11;
        end else begin
            s.ifmt = 1'b1; s.opc = 6'h3F;
        end
        return s;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] alu, add, hi, lo, input logic z);
        exp_t e;
        e.alu = alu; e.add = add; e.hi = hi; e.lo = lo; e.zero = z; e.cyc = 0;
        return e;
    endfunction

    function automatic stim_t mk_op(input logic [W-1:0] rs, rt, imm, pc,
                                    input logic [5:0] funct, opc, input logic [1:0] aluop,
                                    input logic [4:0] shamt, input logic sftmd, ifmt);
        stim_t s;
        s.rs = rs; s.rt = rt; s.imm = imm; s.pc = pc; s.funct = funct; s.opc = opc;
        s.aluop = aluop; s.shamt = shamt; s.sftmd = sftmd; s.alusrc = ifmt;
        s.ifmt = ifmt; s.jrn = 1'b0;
        return s;
    endfunction

    // Called on the falling-edge phase with the DUT idle; start is taken at the next edge.
    // While busy, start is held high with scrambled operands, which must all be ignored.
    task automatic run_op(input stim_t s, input int abort_at, input bit use_exp, input exp_t dexp);
        exp_t e;
        int   lat;
        drive(s);
        start = 1'b1;
        predict(s, e, lat);
        if (use_exp) begin
            e.alu = dexp.alu; e.add = dexp.add; e.hi = dexp.hi; e.lo = dexp.lo; e.zero = dexp.zero;
        end
        @(posedge clock);
        #1;
        if (abort_at < 0) begin
            e.cyc = cyc + lat;
            sbq.push_back(e);
        end
        for (int k = 0; ; k++) begin
            @(negedge clock);
            if (!busy) begin
                start = 1'b0;
                break;
            end
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk("abort_hi", Hi, 0);
                chk("abort_lo", Lo, 0);
                chk("abort_done", done, 0);
                chk("abort_busy", busy, 0);
                @(negedge clock);
                reset = 1'b0;
                start = 1'b0;
                m_alu = '0; m_hi = '0; m_lo = '0; m_zero = 1'b0;
                break;
            end
            if (k > W + 8) begin
                n_cmp++; n_fail++;
                $display("FAIL busy_timeout: busy still 1 after %0d cycles, required idle", k);
                start = 1'b0;
                break;
            end
            drive(gen_rand());
            start = 1'b1;
        end
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required 0", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("alu_result", ALU_Result, e.alu);
                chk("add_result", Add_Result, e.add);
                chk("zero", Zero, e.zero);
                chk("hi", Hi, e.hi);
                chk("lo", Lo, e.lo);
                chk("busy_at_done", busy, 1);
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t ignore;
        ignore = mk('0, '0, '0, '0, 1'b0);
        #12;
        chk("rst_alu", ALU_Result, 0);
        chk("rst_add", Add_Result, 0);
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_zero", Zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clock);
        #1 reset = 1'b0;

        // add issued on the very first edge after reset release
        run_op(mk_op(5, 6, 0, 0, 6'h20, 6'h00, 2'b10, 0, 0, 0), -1, 1,
               mk(32'h0000000B, 0, 0, 0, 1'b0));
        run_op(mk_op(3, 0, 32'hFFFFFF40, 8, 6'h00, 6'h08, 2'b10, 0, 0, 1), -1, 1,
               mk(32'hFFFFFF43, 32'hFFFFFD08, 0, 0, 1'b0));
        run_op(mk_op(0, 2, 0, 0, 6'h00, 6'h00, 2'b10, 3, 1, 0), -1, 1,
               mk(32'h00000010, 0, 0, 0, 1'b0));
        run_op(mk_op(0, 0, 32'h00000040, 0, 6'h00, 6'h0F, 2'b10, 0, 0, 1), -1, 1,
               mk(32'h00400000, 32'h00000100, 0, 0, 1'b0));
        run_op(mk_op(1, 1, 4, 32'h18, 6'h00, 6'h04, 2'b01, 0, 0, 0), -1, 1,
               mk(0, 32'h28, 0, 0, 1'b1));
        run_op(mk_op(32'hFFFFFFFF, 2, 0, 0, 6'h19, 6'h00, 2'b10, 0, 0, 0), -1, 1,
               mk(0, 0, 32'h1, 32'hFFFFFFFE, 1'b1));
        run_op(mk_op(7, 0, 0, 0, 6'h1B, 6'h00, 2'b10, 0, 0, 0), -1, 1,
               mk(0, 0, 32'h7, 32'hFFFFFFFF, 1'b1));
        run_op(mk_op(100, 7, 0, 0, 6'h1B, 6'h00, 2'b10, 0, 0, 0), -1, 1,
               mk(0, 0, 32'h2, 32'hE, 1'b1));
        run_op(mk_op(100, 7, 0, 0, 6'h1B, 6'h00, 2'b10, 0, 0, 0), 9, 0, ignore);
        repeat (W + 5) @(negedge clock);

        for (int i = 0; i < 60; i++) run_op(gen_rand(), -1, 0, ignore);

        repeat (3) @(negedge clock);
        chk("queue_empty", 64'(sbq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
